// File: rtl/debug_run_controller.sv
// Run/step sequencer for the debug-controlled MIPS pipeline: owns the global advance
// enable, handles RUN/STEP/HALT, PC breakpoint, end-of-program drain and MISO arbitration.
module debug_run_controller #(
  parameter int NB_BITS      = 32,
  parameter int NB_CS        = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  input  logic [2:0]         i_cmd,
  input  logic [NB_BITS-1:0] i_cmd_arg,
  input  logic [NB_BITS-1:0] i_pc,
  input  logic               i_end_instr,
  input  logic [NB_CS-1:0]   i_miso,
  input  logic [NB_CS-1:0]   i_spi_cs,
  output logic               o_debug_enb,
  output logic [1:0]         o_state,
  output logic [1:0]         o_halt_cause,
  output logic [NB_BITS-1:0] o_cycle_cnt,
  output logic               o_miso,
  output logic               o_cs_err
);

  localparam logic [1:0] S_HALTED = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [1:0] C_RESET = 2'd0;
  localparam logic [1:0] C_HOST  = 2'd1;
  localparam logic [1:0] C_BREAK = 2'd2;
  localparam logic [1:0] C_END   = 2'd3;

  localparam logic [2:0] CMD_RUN     = 3'd1;
  localparam logic [2:0] CMD_STEP    = 3'd2;
  localparam logic [2:0] CMD_HALT    = 3'd3;
  localparam logic [2:0] CMD_SET_BP  = 3'd4;
  localparam logic [2:0] CMD_CLR_BP  = 3'd5;
  localparam logic [2:0] CMD_CLR_CNT = 3'd6;

  localparam logic [NB_BITS-1:0] ONE        = {{(NB_BITS-1){1'b0}}, 1'b1};
  localparam logic [3:0]         DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [NB_CS-1:0]   CS_ONE     = {{(NB_CS-1){1'b0}}, 1'b1};

  logic [1:0]         state, state_next;
  logic [1:0]         cause_next;
  logic [NB_BITS-1:0] step_cnt;
  logic [NB_BITS-1:0] bp_addr;
  logic               bp_en;
  logic               skip;
  logic [3:0]         drain_cnt;
  logic               bp_hit;

  logic cmd_run, cmd_step, cmd_halt, cmd_set_bp, cmd_clr_bp, cmd_clr_cnt;

  assign cmd_run     = i_cmd_valid && (i_cmd == CMD_RUN);
  assign cmd_step    = i_cmd_valid && (i_cmd == CMD_STEP);
  assign cmd_halt    = i_cmd_valid && (i_cmd == CMD_HALT);
  assign cmd_set_bp  = i_cmd_valid && (i_cmd == CMD_SET_BP);
  assign cmd_clr_bp  = i_cmd_valid && (i_cmd == CMD_CLR_BP);
  assign cmd_clr_cnt = i_cmd_valid && (i_cmd == CMD_CLR_CNT);

  // skip masks the hit for one cycle so a resume at the breakpoint PC moves on
  assign bp_hit = bp_en && !skip && (i_pc == bp_addr) &&
                  ((state == S_RUN) || (state == S_STEP));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_HALTED;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cause_next = o_halt_cause;
    case (state)
      S_HALTED: begin
        if (cmd_run)       state_next = S_RUN;
        else if (cmd_step) state_next = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (i_end_instr) begin
          state_next = S_DRAIN;
        end else if (bp_hit) begin
          state_next = S_HALTED;
          cause_next = C_BREAK;
        end else if (cmd_halt || ((state == S_STEP) && (step_cnt == ONE))) begin
          state_next = S_HALTED;
          cause_next = C_HOST;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == 4'd1) begin
          state_next = S_HALTED;
          cause_next = C_END;
        end
      end
      default: state_next = S_HALTED;
    endcase
  end

  always_comb begin
    o_state     = state;
    o_debug_enb = (state != S_HALTED);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cycle_cnt  <= '0;
      o_halt_cause <= C_RESET;
      bp_en        <= 1'b0;
      bp_addr      <= '0;
      step_cnt     <= '0;
      drain_cnt    <= '0;
      skip         <= 1'b0;
    end else begin
      if (cmd_clr_cnt)
        o_cycle_cnt <= '0;
      else if (o_debug_enb && (o_cycle_cnt != '1))
        o_cycle_cnt <= o_cycle_cnt + ONE;

      if (cmd_set_bp) begin
        bp_en   <= 1'b1;
        bp_addr <= i_cmd_arg;
      end else if (cmd_clr_bp) begin
        bp_en <= 1'b0;
      end

      if ((state == S_HALTED) && (state_next == S_STEP))
        step_cnt <= (i_cmd_arg == '0) ? ONE : i_cmd_arg;
      else if (state == S_STEP)
        step_cnt <= step_cnt - ONE;

      if ((state != S_DRAIN) && (state_next == S_DRAIN))
        drain_cnt <= DRAIN_LOAD;
      else if (state == S_DRAIN)
        drain_cnt <= drain_cnt - 4'd1;

      skip         <= (state == S_HALTED) && (state_next != S_HALTED);
      o_halt_cause <= cause_next;
    end
  end

  // Only a single low chip select may reach the host; x & (x-1) is nonzero for 2+ bits set
  logic [NB_CS-1:0] cs_low;
  logic             cs_multi;
  logic             cs_single;

  always_comb begin
    cs_low    = ~i_spi_cs;
    cs_multi  = (cs_low & (cs_low - CS_ONE)) != '0;
    cs_single = (cs_low != '0) && !cs_multi;
    o_miso    = cs_single && |(i_miso & cs_low);
    o_cs_err  = cs_multi;
  end

endmodule

// File: tb/tb_debug_run_controller.sv
// Bench for debug_run_controller: directed test-plan steps, then random commands checked
// against an event-level reference model of the run/step/drain behaviour.
module tb_debug_run_controller;

  localparam int NB      = 8;
  localparam int NCS     = 4;
  localparam int DRAIN   = 4;
  localparam int CNT_MAX = (1 << NB) - 1;

  localparam int M_HALTED = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3;
  localparam logic [2:0] K_NOP = 3'd0, K_RUN = 3'd1, K_STEP = 3'd2, K_HALT = 3'd3,
                         K_SET_BP = 3'd4, K_CLR_BP = 3'd5, K_CLR_CNT = 3'd6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd = '0;
  logic [NB-1:0] cmd_arg = '0;
  logic [NB-1:0] pc = '0;
  logic          end_instr = 1'b0;
  logic [NCS-1:0] miso = '0;
  logic [NCS-1:0] spi_cs = '1;
  logic          debug_enb;
  logic [1:0]    state;
  logic [1:0]    halt_cause;
  logic [NB-1:0] cycle_cnt;
  logic          miso_out;
  logic          cs_err;

  int checks = 0;
  int errors = 0;
  int en_seen = 0;

  debug_run_controller #(.NB_BITS(NB), .NB_CS(NCS), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .i_cmd_arg(cmd_arg),
    .i_pc(pc), .i_end_instr(end_instr), .i_miso(miso), .i_spi_cs(spi_cs),
    .o_debug_enb(debug_enb), .o_state(state), .o_halt_cause(halt_cause),
    .o_cycle_cnt(cycle_cnt), .o_miso(miso_out), .o_cs_err(cs_err)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus "cycles remaining" bookkeeping, updated once per edge
  int          m_mode = M_HALTED;
  int          m_cause = 0;
  int          m_cnt = 0;
  int          m_steps = 0;
  int          m_drain = 0;
  bit          m_bp_on = 0;
  logic [NB-1:0] m_bp_addr = '0;
  bit          m_fresh = 0;
  bit          m_was_enabled, m_hit;
  int          m_c;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_HALTED; m_cause = 0; m_cnt = 0; m_steps = 0; m_drain = 0;
      m_bp_on = 0; m_bp_addr = '0; m_fresh = 0;
    end else begin
      m_c = cmd_valid ? int'(cmd) : 0;
      m_was_enabled = (m_mode != M_HALTED);
      m_hit = m_bp_on && (pc == m_bp_addr) && !m_fresh && (m_mode == M_RUN || m_mode == M_STEP);
      if (m_c == 6) m_cnt = 0;
      else if (m_was_enabled && m_cnt < CNT_MAX) m_cnt++;
      m_fresh = 0;
      if (m_mode == M_HALTED) begin
        if (m_c == 1) begin m_mode = M_RUN; m_fresh = 1; end
        else if (m_c == 2) begin
          m_mode = M_STEP; m_steps = (cmd_arg == 0) ? 1 : int'(cmd_arg); m_fresh = 1;
        end
      end else if (m_mode == M_DRAIN) begin
        m_drain--;
        if (m_drain == 0) begin m_mode = M_HALTED; m_cause = 3; end
      end else begin
        if (m_mode == M_STEP) m_steps--;
        if (end_instr) begin m_mode = M_DRAIN; m_drain = DRAIN; end
        else if (m_hit) begin m_mode = M_HALTED; m_cause = 2; end
        else if (m_c == 3) begin m_mode = M_HALTED; m_cause = 1; end
        else if (m_mode == M_STEP && m_steps == 0) begin m_mode = M_HALTED; m_cause = 1; end
      end
      if (m_c == 4) begin m_bp_on = 1; m_bp_addr = cmd_arg; end
      else if (m_c == 5) m_bp_on = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit v, input logic [2:0] c, input logic [NB-1:0] a,
                      input logic [NB-1:0] p, input bit e);
    @(negedge clk);
    cmd_valid = v; cmd = c; cmd_arg = a; pc = p; end_instr = e;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; end_instr = 1'b0;
    check("state", 32'(state), 32'(m_mode));
    check("debug_enb", 32'(debug_enb), 32'(m_mode != M_HALTED));
    check("halt_cause", 32'(halt_cause), 32'(m_cause));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    if (debug_enb) en_seen++;
  endtask

  task automatic check_miso(input logic [NCS-1:0] cs, input logic [NCS-1:0] m);
    int nlow;
    logic exp_m;
    nlow = 0; exp_m = 1'b0;
    spi_cs = cs; miso = m;
    #1;
    for (int i = 0; i < NCS; i++) begin
      if (!cs[i]) begin nlow++; exp_m = m[i]; end
    end
    check("miso", 32'(miso_out), 32'((nlow == 1) ? exp_m : 1'b0));
    check("cs_err", 32'(cs_err), 32'(nlow > 1));
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(M_HALTED));
    check("rst_enb", 32'(debug_enb), 32'(0));
    check("rst_cause", 32'(halt_cause), 32'(0));
    check("rst_cnt", 32'(cycle_cnt), 32'(0));

    // STEP 3
    en_seen = 0;
    tick(1, K_STEP, 8'd3, 8'h00, 0);
    repeat (4) tick(0, K_NOP, 8'd0, 8'h00, 0);
    check("step3_enabled", 32'(en_seen), 32'(3));
    check("step3_state", 32'(state), 32'(M_HALTED));
    check("step3_cause", 32'(halt_cause), 32'(1));
    check("step3_cnt", 32'(cycle_cnt), 32'(3));

    // STEP 0 behaves as STEP 1
    en_seen = 0;
    tick(1, K_STEP, 8'd0, 8'h00, 0);
    repeat (3) tick(0, K_NOP, 8'd0, 8'h00, 0);
    check("step0_enabled", 32'(en_seen), 32'(1));
    check("step0_state", 32'(state), 32'(M_HALTED));

    // Breakpoint at 0x10, PC walking by 4
    tick(1, K_SET_BP, 8'h10, 8'h00, 0);
    tick(1, K_RUN, 8'd0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) tick(0, K_NOP, 8'd0, 8'(i * 4), 0);
    check("bp_state", 32'(state), 32'(M_HALTED));
    check("bp_cause", 32'(halt_cause), 32'(2));
    tick(1, K_RUN, 8'd0, 8'h10, 0);
    tick(0, K_NOP, 8'd0, 8'h10, 0);
    check("bp_resume_state", 32'(state), 32'(M_RUN));
    tick(0, K_NOP, 8'd0, 8'h14, 0);
    check("bp_resume_past", 32'(state), 32'(M_RUN));
    tick(1, K_HALT, 8'd0, 8'h18, 0);
    check("halt_cause_host", 32'(halt_cause), 32'(1));

    // End of program beats a same-cycle HALT; HALT while draining is ignored
    tick(1, K_RUN, 8'd0, 8'h40, 0);
    tick(0, K_NOP, 8'd0, 8'h44, 0);
    en_seen = 0;
    tick(1, K_HALT, 8'd0, 8'h48, 1);
    check("drain_entry", 32'(state), 32'(M_DRAIN));
    tick(1, K_HALT, 8'd0, 8'h4c, 0);
    check("drain_halt_ignored", 32'(state), 32'(M_DRAIN));
    repeat (4) tick(0, K_NOP, 8'd0, 8'h50, 0);
    check("drain_enabled", 32'(en_seen), 32'(4));
    check("drain_cause", 32'(halt_cause), 32'(3));

    // MISO arbitration
    check_miso(4'b1101, 4'b0010);
    check("miso_sel1", 32'(miso_out), 32'(1));
    check_miso(4'b1100, 4'b1111);
    check("miso_multi", 32'(miso_out), 32'(0));
    check("cs_err_multi", 32'(cs_err), 32'(1));
    check_miso(4'b1111, 4'b1111);
    check("cs_err_none", 32'(cs_err), 32'(0));
    for (int i = 0; i < 24; i++) check_miso(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    spi_cs = '1;

    // Async reset mid-RUN
    tick(1, K_RUN, 8'd0, 8'h20, 0);
    tick(0, K_NOP, 8'd0, 8'h24, 0);
    @(negedge clk); #2; rst = 1'b1; #1;
    check("async_enb", 32'(debug_enb), 32'(0));
    check("async_state", 32'(state), 32'(M_HALTED));
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_cause", 32'(halt_cause), 32'(0));
    check("post_rst_cnt", 32'(cycle_cnt), 32'(0));
    tick(1, K_RUN, 8'd0, 8'h10, 0);
    tick(0, K_NOP, 8'd0, 8'h10, 0);
    tick(0, K_NOP, 8'd0, 8'h10, 0);
    check("post_rst_bp_off", 32'(state), 32'(M_RUN));
    tick(1, K_CLR_CNT, 8'd0, 8'h14, 0);
    check("clr_cnt_run", 32'(cycle_cnt), 32'(0));

    // Saturation of the cycle counter
    repeat (CNT_MAX + 5) tick(0, K_NOP, 8'd0, 8'h30, 0);
    check("cnt_saturated", 32'(cycle_cnt), 32'(CNT_MAX));
    tick(1, K_HALT, 8'd0, 8'h30, 0);
    tick(1, K_CLR_CNT, 8'd0, 8'h30, 0);

    // Random command stream
    for (int i = 0; i < 1500; i++) begin
      logic          v;
      logic [2:0]    c;
      logic [NB-1:0] a;
      v = ($urandom_range(0, 9) < 3);
      c = 3'($urandom_range(0, 7));
      a = (c == K_STEP) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 7) * 4);
      tick(v, c, a, 8'($urandom_range(0, 7) * 4), ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
